// File: rtl/reg_read_port_pkg.sv
// reg_read_port_pkg: shared sizing constants for the register-file read port
package reg_read_port_pkg;
  localparam int DATA_W = 16;
  localparam int NUM_REGS = 16;
  localparam int ID_W = 4;
  localparam logic [ID_W-1:0] REG_ZERO = '0;
  localparam logic [NUM_REGS-1:0] ONE_HOT0 = 1;
endpackage

// File: rtl/reg_read_port_read_decoder_4_16.sv
// read_decoder_4_16: source register ID to one-hot bitline select
module read_decoder_4_16
  import reg_read_port_pkg::*;
(
  input  logic [ID_W-1:0]     id,
  output logic [NUM_REGS-1:0] sel
);
  assign sel = ONE_HOT0 << id;
endmodule

// File: rtl/reg_read_port.sv
// reg_read_port: register array read side with scoreboard stall and writeback bypass
module reg_read_port
  import reg_read_port_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_req,
  output logic                rd_ready,
  input  logic [ID_W-1:0]     SrcReg1,
  input  logic [ID_W-1:0]     SrcReg2,
  input  logic                alloc_en,
  input  logic [ID_W-1:0]     alloc_reg,
  input  logic                WriteReg,
  input  logic [ID_W-1:0]     DstReg,
  input  logic [DATA_W-1:0]   DstData,
  output logic [DATA_W-1:0]   SrcData1,
  output logic [DATA_W-1:0]   SrcData2,
  output logic                rd_valid,
  output logic [NUM_REGS-1:0] busy_vec
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] sel1, sel2, wl, alloc_set, busy_nxt;
  logic [DATA_W-1:0] rd1, rd2;
  logic byp1, byp2, haz1, haz2, accept;

  read_decoder_4_16 u_dec1 (.id(SrcReg1), .sel(sel1));
  read_decoder_4_16 u_dec2 (.id(SrcReg2), .sel(sel2));

  assign byp1 = WriteReg && DstReg == SrcReg1 && SrcReg1 != REG_ZERO;
  assign byp2 = WriteReg && DstReg == SrcReg2 && SrcReg2 != REG_ZERO;
  assign haz1 = busy_vec[SrcReg1] && !byp1;
  assign haz2 = busy_vec[SrcReg2] && !byp2;
  assign rd_ready = !haz1 && !haz2;
  assign accept = rd_req && rd_ready;
  assign wl = (WriteReg && DstReg != REG_ZERO) ? ONE_HOT0 << DstReg : '0;
  assign alloc_set = (alloc_en && accept && alloc_reg != REG_ZERO) ? ONE_HOT0 << alloc_reg : '0;
  assign busy_nxt = (busy_vec & ~wl) | alloc_set;

  // one-hot bitline mux; R0 is never written so it always reads zero
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd1 = rd1 | (sel1[i] ? regs[i] : '0);
      rd2 = rd2 | (sel2[i] ? regs[i] : '0);
    end
  end

  // register array written through the gated wordline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) if (wl[i]) regs[i] <= DstData;
    end
  end

  // operand registers, valid flag and pending-write scoreboard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SrcData1 <= '0;
      SrcData2 <= '0;
      rd_valid <= 1'b0;
      busy_vec <= '0;
    end else begin
      rd_valid <= accept;
      busy_vec <= busy_nxt;
      if (accept) begin
        SrcData1 <= byp1 ? DstData : rd1;
        SrcData2 <= byp2 ? DstData : rd2;
      end
    end
  end
endmodule
